// File: rtl/bpc_plane_seq_pkg.sv
// Shared definitions for the bit-plane coder sequencer.
//  - W_WT1      : MSB index of one sign-magnitude coefficient
//  - COEF_W     : width of one coefficient (W_WT1+1)
//  - state_e    : sequencer FSM states
//  - clog2_min1 : ceil(log2(n)), never smaller than 1, for counter widths
package bpc_plane_seq_pkg;

  localparam int W_WT1  = 7;
  localparam int COEF_W = W_WT1 + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PSTART = 3'd1,
    ST_SCAN   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bpc_plane_seq_scan_addr.sv
// Stripe/column scan counters for one bit plane of a code-block.
// Ports:
//  clk_i        clock
//  rstn_i       async reset, active low
//  clr_i        restart the scan at stripe 0, column 0
//  adv_i        a word was issued this cycle; step to the next column
//  rd_addr_o    word address = stripe*CB_W + col
//  first_row_o  current position is in stripe 0
//  first_col_o  current position is column 0
//  last_col_o   current position is column CB_W-1
//  last_word_o  current position is the final word of the plane
module bpc_plane_seq_scan_addr
  import bpc_plane_seq_pkg::*;
#(
  parameter int CB_W = 8,
  parameter int CB_H = 8,
  parameter int AW   = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [AW-1:0] rd_addr_o,
  output logic          first_row_o,
  output logic          first_col_o,
  output logic          last_col_o,
  output logic          last_word_o
);

  localparam int NSTRIPE = CB_H / 4;
  localparam int COL_W   = clog2_min1(CB_W);
  localparam int STR_W   = clog2_min1(NSTRIPE);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(CB_W - 1);
  localparam logic [STR_W-1:0] STR_LAST = STR_W'(NSTRIPE - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [STR_W-1:0] stripe_q, stripe_d;

  // Next scan position: column-major inside a stripe, wrapping to the next stripe.
  always_comb begin
    col_d    = col_q;
    stripe_d = stripe_q;
    if (clr_i) begin
      col_d    = '0;
      stripe_d = '0;
    end else if (adv_i) begin
      if (col_q == COL_LAST) begin
        col_d    = '0;
        // Wrapping after the last word leaves the counters ready for the next plane.
        stripe_d = (stripe_q == STR_LAST) ? '0 : stripe_q + STR_W'(1);
      end else begin
        col_d    = col_q + COL_W'(1);
        stripe_d = stripe_q;
      end
    end else begin
      col_d    = col_q;
      stripe_d = stripe_q;
    end
  end

  // Scan position registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col_q    <= '0;
      stripe_q <= '0;
    end else begin
      col_q    <= col_d;
      stripe_q <= stripe_d;
    end
  end

  // CB_W is a power of two, so stripe*CB_W + col is a plain concatenation.
  assign rd_addr_o   = AW'({stripe_q, col_q});
  assign first_row_o = (stripe_q == '0);
  assign first_col_o = (col_q == '0);
  assign last_col_o  = (col_q == COL_LAST);
  assign last_word_o = (col_q == COL_LAST) && (stripe_q == STR_LAST);

endmodule

// File: rtl/bpc_plane_seq.sv
// Bit-plane coder sequencer: walks one code-block plane by plane (MSB first),
// reading column words from the code-block SRAM and presenting them to bpc.
// Ports:
//  clk, rstn                 clock, async active-low reset
//  start, num_planes,        begin a code-block (IDLE only); plane count 0..16;
//  band_in                   subband id latched on the accepted start
//  stall                     downstream almost-full, holds back new reads
//  rd_en, rd_addr, rd_data   code-block SRAM port (data valid one cycle after rd_en)
//  coeff0..3, coef_en        returned word split into 4 coefficients, row0 = coeff0
//  first_row/col, last_col   position flags aligned with coef_en
//  first_plane, bit_pos,     plane context, constant over a whole plane
//  band
//  plane_start, plane_end    strobes before the first column / in the last drain cycle
//  busy, done                activity indicator and completion pulse
module bpc_plane_seq
  import bpc_plane_seq_pkg::*;
#(
  parameter int CB_W      = 8,
  parameter int CB_H      = 8,
  parameter int AW        = 4,
  parameter int DRAIN_CYC = 6
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [4:0]          num_planes,
  input  logic [1:0]          band_in,
  input  logic                stall,
  output logic                rd_en,
  output logic [AW-1:0]       rd_addr,
  input  logic [4*COEF_W-1:0] rd_data,
  output logic [COEF_W-1:0]   coeff0,
  output logic [COEF_W-1:0]   coeff1,
  output logic [COEF_W-1:0]   coeff2,
  output logic [COEF_W-1:0]   coeff3,
  output logic                coef_en,
  output logic                first_row,
  output logic                first_col,
  output logic                last_col,
  output logic                first_plane,
  output logic [3:0]          bit_pos,
  output logic [1:0]          band,
  output logic                plane_start,
  output logic                plane_end,
  output logic                busy,
  output logic                done
);

  localparam int DR_W = clog2_min1(DRAIN_CYC);
  localparam logic [DR_W-1:0] DRAIN_LAST = DR_W'(DRAIN_CYC - 1);

  state_e          state_q, state_d;
  logic [DR_W-1:0] drain_q, drain_d;
  logic [3:0]      bit_pos_q, bit_pos_d;
  logic            first_plane_q, first_plane_d;
  logic [1:0]      band_q, band_d;
  logic            coef_en_q, first_row_q, first_col_q, last_col_q;

  logic            issue_s;
  logic            sc_first_row_s, sc_first_col_s, sc_last_col_s, sc_last_word_s;

  // A word is issued on every non-stalled SCAN cycle; the in-flight word is never held back.
  assign issue_s = (state_q == ST_SCAN) && !stall;

  bpc_plane_seq_scan_addr #(
    .CB_W (CB_W),
    .CB_H (CB_H),
    .AW   (AW)
  ) u_scan (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .clr_i       (state_q == ST_PSTART),
    .adv_i       (issue_s),
    .rd_addr_o   (rd_addr),
    .first_row_o (sc_first_row_s),
    .first_col_o (sc_first_col_s),
    .last_col_o  (sc_last_col_s),
    .last_word_o (sc_last_word_s)
  );

  // FSM next state plus the per-block / per-plane context registers.
  always_comb begin
    state_d       = state_q;
    drain_d       = '0;
    bit_pos_d     = bit_pos_q;
    first_plane_d = first_plane_q;
    band_d        = band_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          band_d = band_in;
          if (num_planes != 5'd0) begin
            state_d       = ST_PSTART;
            // Out-of-range plane counts are clamped to the 16-plane maximum.
            bit_pos_d     = (num_planes > 5'd16) ? 4'd15 : 4'(num_planes - 5'd1);
            first_plane_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PSTART: begin
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (issue_s && sc_last_word_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_DRAIN: begin
        // Drain length is fixed; stall has no effect here.
        if (drain_q == DRAIN_LAST) begin
          if (bit_pos_q != 4'd0) begin
            state_d       = ST_PSTART;
            bit_pos_d     = bit_pos_q - 4'd1;
            first_plane_d = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          drain_d = drain_q + DR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and context registers; reset aborts any block without a done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      drain_q       <= '0;
      bit_pos_q     <= 4'd0;
      first_plane_q <= 1'b0;
      band_q        <= 2'd0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      bit_pos_q     <= bit_pos_d;
      first_plane_q <= first_plane_d;
      band_q        <= band_d;
    end
  end

  // Output stage: delay issue-side flags by one cycle to line up with rd_data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      coef_en_q   <= 1'b0;
      first_row_q <= 1'b0;
      first_col_q <= 1'b0;
      last_col_q  <= 1'b0;
    end else begin
      coef_en_q   <= issue_s;
      first_row_q <= issue_s && sc_first_row_s;
      first_col_q <= issue_s && sc_first_col_s;
      last_col_q  <= issue_s && sc_last_col_s;
    end
  end

  assign rd_en       = issue_s;
  assign coef_en     = coef_en_q;
  assign first_row   = first_row_q;
  assign first_col   = first_col_q;
  assign last_col    = last_col_q;
  // Coefficients are forced to zero outside valid words so reset leaves every output at 0.
  assign coeff0      = coef_en_q ? rd_data[0*COEF_W +: COEF_W] : '0;
  assign coeff1      = coef_en_q ? rd_data[1*COEF_W +: COEF_W] : '0;
  assign coeff2      = coef_en_q ? rd_data[2*COEF_W +: COEF_W] : '0;
  assign coeff3      = coef_en_q ? rd_data[3*COEF_W +: COEF_W] : '0;
  assign first_plane = first_plane_q;
  assign bit_pos     = bit_pos_q;
  assign band        = band_q;
  assign plane_start = (state_q == ST_PSTART);
  assign plane_end   = (state_q == ST_DRAIN) && (drain_q == DRAIN_LAST);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

endmodule
